mux_sel_sequencer: RTL

//   Upstream control stage for the 4:1 mux: round-robin arbiter over 4 request lines.

---
 rtl/mux_sel_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for a 4:1 mux: grants, settles DWELL cycles, flags valid.
// Optional MUXSEQ_LOCK_EN adds a lock input that re-grants the same channel on ack.
module mux_sel_sequencer #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       sel_valid
`ifdef MUXSEQ_LOCK_EN
    ,
    input  logic       lock
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       sel_valid_q, sel_valid_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] base;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_any;
    logic       relock;

    // In VALID the acked channel becomes the new pointer, so search from sel.
    always_comb begin
        base    = (state_q == VALID) ? sel_q : ptr_q;
        cand    = base;
        win_any = 1'b0;
        win_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = base + 2'(k);
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef MUXSEQ_LOCK_EN
    assign relock = lock && req[sel_q];
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        sel_valid_d = sel_valid_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                sel_valid_d = 1'b0;
                gnt_d       = 4'b0000;
                if (win_any) begin
                    sel_d   = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    cnt_d   = 4'(DWELL - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                sel_valid_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d     = VALID;
                    sel_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            VALID: begin
                if (ack) begin
                    sel_valid_d = 1'b0;
                    if (relock) begin
                        cnt_d   = 4'(DWELL - 1);
                        state_d = SETTLE;
                    end else if (win_any) begin
                        ptr_d   = sel_q;
                        sel_d   = win_idx;
                        gnt_d   = 4'b0001 << win_idx;
                        cnt_d   = 4'(DWELL - 1);
                        state_d = SETTLE;
                    end else begin
                        ptr_d   = sel_q;
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                sel_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'b00;
            gnt_q       <= 4'b0000;
            sel_valid_q <= 1'b0;
            ptr_q       <= 2'b11;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            sel_valid_q <= sel_valid_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign sel_valid = sel_valid_q;

endmodule
